// File: rtl/seg_scan_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seg_scan_scheduler_pkg                                         |
// | Purpose : Shared constants for the seven-segment scan path: digit code   |
// |           values, active-low segment patterns, anode-off value, scan     |
// |           FSM state encoding and the hex-to-segment lookup.              |
// | Ports   : none (package)                                                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package seg_scan_scheduler_pkg;

  localparam logic [4:0] SEG_DASH  = 5'd16;
  localparam logic [4:0] SEG_BLANK = 5'd31;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] CA_DASH  = 7'b0111111;
  localparam logic [6:0] CA_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  function automatic logic [6:0] hex_to_ca(input logic [3:0] nib);
    logic [6:0] ca;
    case (nib)
      4'h0: ca = 7'b1000000;
      4'h1: ca = 7'b1111001;
      4'h2: ca = 7'b0100100;
      4'h3: ca = 7'b0110000;
      4'h4: ca = 7'b0011001;
      4'h5: ca = 7'b0010010;
      4'h6: ca = 7'b0000010;
      4'h7: ca = 7'b1111000;
      4'h8: ca = 7'b0000000;
      4'h9: ca = 7'b0010000;
      4'hA: ca = 7'b0001000;
      4'hB: ca = 7'b0000011;
      4'hC: ca = 7'b1000110;
      4'hD: ca = 7'b0100001;
      4'hE: ca = 7'b0000110;
      default: ca = 7'b0001110;
    endcase
    return ca;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seg_scan_scheduler_if                                          |
// | Purpose : Frame transfer bus into the scan scheduler (valid/ready).      |
// | Ports   : frame_valid  producer -> scheduler, frame data valid           |
// |           frame_ready  scheduler -> producer, shadow buffer empty        |
// |           frame_digits 8 x 5-bit digit codes, digit 0 in [4:0]           |
// |           frame_dp     per-digit decimal point, 1 = lit                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface seg_scan_scheduler_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [39:0] frame_digits;
  logic [7:0]  frame_dp;

  modport master (output frame_valid, frame_digits, frame_dp, input frame_ready);
  modport slave  (input frame_valid, frame_digits, frame_dp, output frame_ready);
endinterface
`default_nettype wire

// File: rtl/seg_scan_scheduler_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seg_decoder                                                    |
// | Purpose : Combinational 5-bit digit code to active-low segment pattern.  |
// |           0-15 hex, 16 dash, 17-31 blank.                                |
// | Ports   : code_i [4:0] digit code                                        |
// |           ca_o   [6:0] segments {g..a}, active-low                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module seg_decoder
  import seg_scan_scheduler_pkg::*;
(
  input  wire logic [4:0] code_i,
  output logic      [6:0] ca_o
);

  always_comb begin
    ca_o = CA_BLANK;
    if (!code_i[4])             ca_o = hex_to_ca(code_i[3:0]);
    else if (code_i == SEG_DASH) ca_o = CA_DASH;
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seg_scan_scheduler                                             |
// | Purpose : Time-multiplexed scan of an 8-digit common-anode display with  |
// |           double-buffered, tear-free frame updates and a per-slot blank  |
// |           guard against ghosting.                                        |
// | Ports   : clk_100MHz  system clock                                       |
// |           reset       asynchronous, active-high                          |
// |           enable      scan enable, 0 = dark and held at digit 0          |
// |           brightness  PWM dim level, 15 = full                           |
// |           frame_bus   frame valid/ready bus (slave side)                 |
// |           frame_swap  1-clk pulse when shadow frame becomes active       |
// |           AN/CA/dp    registered, active-low display pins                |
// | Config  : SEG_PWM_DIM_EN - when defined, anode on-time in DRIVE is       |
// |           limited by brightness; otherwise brightness is ignored.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module seg_scan_scheduler
  import seg_scan_scheduler_pkg::*;
#(
  parameter int TICK_DIV     = 32768,
  parameter int BLANK_CYCLES = 64
)(
  input  wire logic             clk_100MHz,
  input  wire logic             reset,
  input  wire logic             enable,
  input  wire logic [3:0]       brightness,
  seg_scan_scheduler_if.slave   frame_bus,
  output logic                  frame_swap,
  output logic      [7:0]       AN,
  output logic      [6:0]       CA,
  output logic                  dp
);

  localparam int                CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam scan_state_e       SLOT_FIRST = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [39:0]       active_digits_q, shadow_digits_q;
  logic [7:0]        active_dp_q, shadow_dp_q;
  logic              shadow_full_q;
  logic              frame_swap_q;
  logic [7:0]        an_q, an_d;
  logic [6:0]        ca_q, ca_d;
  logic              dp_q, dp_d;

  logic [CNT_W-1:0]  slot_inc;
  logic [5:0]        bit_base;
  logic [6:0]        dec_ca;
  logic              frame_boundary;
  logic              do_swap;
  logic              do_capture;
  logic              lit;

  assign slot_inc = slot_cnt_q + 1'b1;
  assign bit_base = {idx_q, 2'b00} + {3'b000, idx_q};   // idx * 5

  seg_decoder u_decoder (
    .code_i (active_digits_q[bit_base +: 5]),
    .ca_o   (dec_ca)
  );

  // Last clock of digit 7's drive window; the shadow flag is registered so a
  // frame captured on this very cycle waits for the following boundary.
  assign frame_boundary = (state_q == ST_DRIVE) && (slot_cnt_q == CNT_LAST) && (idx_q == 3'd7);
  assign do_swap        = shadow_full_q && ((state_q == ST_IDLE) || frame_boundary);
  assign do_capture     = frame_bus.frame_valid && !shadow_full_q;

  assign frame_bus.frame_ready = ~shadow_full_q;
  assign frame_swap            = frame_swap_q;
  assign AN                    = an_q;
  assign CA                    = ca_q;
  assign dp                    = dp_q;

`ifdef SEG_PWM_DIM_EN
  assign lit = (slot_cnt_q[CNT_W-1 -: 4] <= brightness);
`else
  logic w_unused_brightness;
  assign w_unused_brightness = &{1'b0, brightness};
  assign lit = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    idx_d      = idx_q;
    if (!enable) begin
      state_d    = ST_IDLE;
      slot_cnt_d = '0;
      idx_d      = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = SLOT_FIRST;
          slot_cnt_d = '0;
          idx_d      = 3'd0;
        end
        ST_BLANK: begin
          slot_cnt_d = slot_inc;
          if (slot_inc == BLANK_END) state_d = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (slot_cnt_q == CNT_LAST) begin
            slot_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
            state_d    = SLOT_FIRST;
          end else begin
            slot_cnt_d = slot_inc;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          slot_cnt_d = '0;
          idx_d      = 3'd0;
        end
      endcase
    end
  end

  // Pin values are computed from the current state and registered, giving a
  // fixed one-clock latency and glitch-free outputs.
  always_comb begin
    an_d = AN_OFF;
    ca_d = CA_BLANK;
    dp_d = 1'b1;
    if (state_q == ST_DRIVE) begin
      ca_d = dec_ca;
      dp_d = ~active_dp_q[idx_q];
      if (lit) an_d = ~(8'b1 << idx_q);
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      slot_cnt_q      <= '0;
      idx_q           <= 3'd0;
      active_digits_q <= {8{SEG_BLANK}};
      active_dp_q     <= 8'h00;
      shadow_digits_q <= '0;
      shadow_dp_q     <= 8'h00;
      shadow_full_q   <= 1'b0;
      frame_swap_q    <= 1'b0;
      an_q            <= AN_OFF;
      ca_q            <= CA_BLANK;
      dp_q            <= 1'b1;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      frame_swap_q <= do_swap;
      an_q         <= an_d;
      ca_q         <= ca_d;
      dp_q         <= dp_d;
      // Swap and capture are exclusive: capture needs an empty shadow,
      // swap needs a full one.
      if (do_swap) begin
        active_digits_q <= shadow_digits_q;
        active_dp_q     <= shadow_dp_q;
        shadow_full_q   <= 1'b0;
      end else if (do_capture) begin
        shadow_digits_q <= frame_bus.frame_digits;
        shadow_dp_q     <= frame_bus.frame_dp;
        shadow_full_q   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
